// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding fetch/LSU/memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [1:0]    d_size;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic          busy;

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output d_req, d_we, d_addr, d_wdata, d_size,
        input  d_rdata, d_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ready,
        input  busy
    );

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  d_req, d_we, d_addr, d_wdata, d_size,
        output d_rdata, d_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ready,
        output busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported memory between instruction fetch and load/store (IDLE->ACCESS->DONE).
// Define MEMARB_FAIRNESS_EN to bound fetch starvation to STARVE_MAX consecutive data grants.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]    state_q,     state_d;
    logic          owner_q,     owner_d;     // 1 = load/store owns the port
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q,    mem_be_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] d_rdata_q,   d_rdata_d;
    logic          if_ack_q,    if_ack_d;
    logic          d_ack_q,     d_ack_d;

    logic          any_req;
    logic          grant_data;
    logic          fetch_force;
    logic [3:0]    byte_be;
    logic [3:0]    half_be;
    logic [3:0]    d_be;

    // Lane decode: byte selects one lane by addr[1:0], half selects the pair chosen by addr[1].
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_be[gi] = (bus.d_addr[1:0] == 2'(gi));
        assign half_be[gi] = (bus.d_addr[1] == 1'(gi / 2));
    end

    always_comb begin
        d_be = 4'b1111;
        case (bus.d_size)
            2'b00:   d_be = byte_be;
            2'b01:   d_be = half_be;
            default: d_be = 4'b1111;
        endcase
    end

`ifdef MEMARB_FAIRNESS_EN
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_q, starve_d;

    assign fetch_force = bus.if_req && (starve_q == CW'(STARVE_MAX));

    // Counts data grants that bypassed a waiting fetch; any fetch grant clears it.
    always_comb begin
        starve_d = starve_q;
        if (state_q == S_IDLE && any_req) begin
            if (!grant_data) begin
                starve_d = '0;
            end else if (bus.if_req && starve_q != CW'(STARVE_MAX)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict data priority; STARVE_MAX only matters in the fairness build.
    assign fetch_force = (STARVE_MAX < 0);
`endif

    assign any_req    = bus.if_req || bus.d_req;
    assign grant_data = bus.d_req && !fetch_force;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d     = grant_data;
                    mem_req_d   = 1'b1;
                    mem_we_d    = grant_data && bus.d_we;
                    mem_addr_d  = grant_data ? bus.d_addr  : bus.if_addr;
                    mem_wdata_d = grant_data ? bus.d_wdata : '0;
                    mem_be_d    = grant_data ? d_be        : 4'b1111;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Write completions also capture rdata; the value is simply don't-care.
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (owner_q) begin
                        d_rdata_d = bus.mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // One dead cycle lets the served requester drop its request before re-arbitration.
                state_d = S_IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule
